// File: rtl/decode_pkg.sv
// ----------------------------------------------------------------------------
// decode_pkg
// Shared constants for the instruction decode stage: opcode and funct field
// values, ALU operation codes, FSM state encoding, and immediate extension
// helpers used by the combinational decoder.
// ----------------------------------------------------------------------------
package decode_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct values (instruction bits [5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes presented to the execute stage
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DECODE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Zero-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/decode_logic.sv
// ----------------------------------------------------------------------------
// decode_logic
// Purely combinational decoder: one 32-bit instruction word in, the decoded
// bundle (register addresses, immediate, ALU op, control flags) out.
// Ports:
//   instr_i      32  instruction word
//   rs_addr_o    5   source register (always bits [25:21])
//   rt_addr_o    5   source register (always bits [20:16])
//   rd_addr_o    5   destination register (0 when nothing is written)
//   imm_o        32  extended immediate or jump target
//   alu_op_o     4   ALU operation code
//   reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, use_imm_o,
//   illegal_o    1   control flags
// ----------------------------------------------------------------------------
module decode_logic
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  rs_addr_o,
    output logic [4:0]  rt_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] imm_o,
    output logic [3:0]  alu_op_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        use_imm_o,
    output logic        illegal_o
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rd_s;
    logic       reg_write_s;

    assign op_s      = instr_i[31:26];
    assign funct_s   = instr_i[5:0];
    assign rs_addr_o = instr_i[25:21];
    assign rt_addr_o = instr_i[20:16];
    assign rd_addr_o = rd_s;

    // Register 0 is hard-wired, so a write to it is suppressed here.
    assign reg_write_o = reg_write_s & (rd_s != 5'd0);

    // Opcode/funct decode; everything defaults to the inert (all-zero) bundle.
    always_comb begin
        rd_s        = 5'd0;
        imm_o       = 32'h0000_0000;
        alu_op_o    = ALU_ADD;
        reg_write_s = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        branch_o    = 1'b0;
        jump_o      = 1'b0;
        use_imm_o   = 1'b0;
        illegal_o   = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                rd_s        = instr_i[15:11];
                reg_write_s = 1'b1;
                case (funct_s)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_XOR:  alu_op_o = ALU_XOR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    default: begin
                        // Unknown funct: fall back to the inert bundle.
                        rd_s        = 5'd0;
                        reg_write_s = 1'b0;
                        alu_op_o    = ALU_ADD;
                        illegal_o   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                imm_o       = sext16(instr_i[15:0]);
                alu_op_o    = ALU_ADD;
                rd_s        = instr_i[20:16];
                reg_write_s = 1'b1;
                use_imm_o   = 1'b1;
            end
            OP_ANDI: begin
                imm_o       = zext16(instr_i[15:0]);
                alu_op_o    = ALU_AND;
                rd_s        = instr_i[20:16];
                reg_write_s = 1'b1;
                use_imm_o   = 1'b1;
            end
            OP_ORI: begin
                imm_o       = zext16(instr_i[15:0]);
                alu_op_o    = ALU_OR;
                rd_s        = instr_i[20:16];
                reg_write_s = 1'b1;
                use_imm_o   = 1'b1;
            end
            OP_LW: begin
                imm_o       = sext16(instr_i[15:0]);
                alu_op_o    = ALU_ADD;
                rd_s        = instr_i[20:16];
                reg_write_s = 1'b1;
                use_imm_o   = 1'b1;
                mem_read_o  = 1'b1;
            end
            OP_SW: begin
                imm_o       = sext16(instr_i[15:0]);
                alu_op_o    = ALU_ADD;
                use_imm_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            OP_BEQ: begin
                // Branch offset is in words; convert to a byte offset.
                imm_o    = {sext16(instr_i[15:0]) << 2};
                alu_op_o = ALU_SUB;
                branch_o = 1'b1;
            end
            OP_J: begin
                imm_o  = {4'b0000, instr_i[25:0], 2'b00};
                jump_o = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// ----------------------------------------------------------------------------
// instruction_decode
// Decode pipeline stage. Captures one instruction per DIR/ack_prev handshake,
// decodes it in one registered cycle and holds the decoded bundle on DOR until
// ack_from_next. Illegal encodings are flagged and still passed downstream.
// Ports:
//   clk, reset (async, active-high)
//   DIR / ack_prev / data_in           upstream handshake and instruction word
//   DOR / ack_from_next                downstream handshake
//   data_out                           raw instruction passed through
//   rs_addr, rt_addr, rd_addr, imm, alu_op, reg_write, mem_read, mem_write,
//   branch, jump, use_imm, illegal     registered decoded bundle
// ----------------------------------------------------------------------------
module instruction_decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        DIR,
    output logic        ack_prev,
    input  logic [31:0] data_in,
    output logic        DOR,
    input  logic        ack_from_next,
    output logic [31:0] data_out,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic [3:0]  alu_op,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        use_imm,
    output logic        illegal
);

    state_e      state_q;
    logic [31:0] instr_q;
    logic        ack_prev_q;
    logic        dor_q;
    logic [31:0] data_out_q;
    logic [4:0]  rs_addr_q, rt_addr_q, rd_addr_q;
    logic [31:0] imm_q;
    logic [3:0]  alu_op_q;
    logic        reg_write_q, mem_read_q, mem_write_q;
    logic        branch_q, jump_q, use_imm_q, illegal_q;

    // Decoded bundle of the held instruction, loaded into the output registers.
    logic [4:0]  rs_addr_d, rt_addr_d, rd_addr_d;
    logic [31:0] imm_d;
    logic [3:0]  alu_op_d;
    logic        reg_write_d, mem_read_d, mem_write_d;
    logic        branch_d, jump_d, use_imm_d, illegal_d;

    decode_logic u_decode_logic (
        .instr_i     (instr_q),
        .rs_addr_o   (rs_addr_d),
        .rt_addr_o   (rt_addr_d),
        .rd_addr_o   (rd_addr_d),
        .imm_o       (imm_d),
        .alu_op_o    (alu_op_d),
        .reg_write_o (reg_write_d),
        .mem_read_o  (mem_read_d),
        .mem_write_o (mem_write_d),
        .branch_o    (branch_d),
        .jump_o      (jump_d),
        .use_imm_o   (use_imm_d),
        .illegal_o   (illegal_d)
    );

    // Handshake FSM with registered outputs; the bundle only loads in DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= 32'h0000_0000;
            ack_prev_q  <= 1'b0;
            dor_q       <= 1'b0;
            data_out_q  <= 32'h0000_0000;
            rs_addr_q   <= 5'd0;
            rt_addr_q   <= 5'd0;
            rd_addr_q   <= 5'd0;
            imm_q       <= 32'h0000_0000;
            alu_op_q    <= 4'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            use_imm_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (DIR) begin
                        instr_q    <= data_in;
                        ack_prev_q <= 1'b1;
                        state_q    <= ST_DECODE;
                    end else begin
                        ack_prev_q <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    ack_prev_q  <= 1'b0;
                    data_out_q  <= instr_q;
                    rs_addr_q   <= rs_addr_d;
                    rt_addr_q   <= rt_addr_d;
                    rd_addr_q   <= rd_addr_d;
                    imm_q       <= imm_d;
                    alu_op_q    <= alu_op_d;
                    reg_write_q <= reg_write_d;
                    mem_read_q  <= mem_read_d;
                    mem_write_q <= mem_write_d;
                    branch_q    <= branch_d;
                    jump_q      <= jump_d;
                    use_imm_q   <= use_imm_d;
                    illegal_q   <= illegal_d;
                    dor_q       <= 1'b1;
                    state_q     <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_from_next) begin
                        dor_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        dor_q   <= 1'b1;
                    end
                end
                default: begin
                    ack_prev_q <= 1'b0;
                    dor_q      <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_prev  = ack_prev_q;
    assign DOR       = dor_q;
    assign data_out  = data_out_q;
    assign rs_addr   = rs_addr_q;
    assign rt_addr   = rt_addr_q;
    assign rd_addr   = rd_addr_q;
    assign imm       = imm_q;
    assign alu_op    = alu_op_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign branch    = branch_q;
    assign jump      = jump_q;
    assign use_imm   = use_imm_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instruction_decode.sv
// ----------------------------------------------------------------------------
// tb_instruction_decode
// Self-checking bench: directed vector table, randomized instructions checked
// against a field-level reference model, and hand-written handshake/reset
// sequences.
// ----------------------------------------------------------------------------
module tb_instruction_decode;

    logic        clk;
    logic        reset;
    logic        DIR;
    logic        ack_prev;
    logic [31:0] data_in;
    logic        DOR;
    logic        ack_from_next;
    logic [31:0] data_out;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, branch, jump, use_imm, illegal;

    int checks = 0;
    int errors = 0;

    // flag vector bit positions: {reg_write,mem_read,mem_write,branch,jump,use_imm,illegal}
    localparam int F_RW = 6;
    localparam int F_MR = 5;
    localparam int F_MW = 4;
    localparam int F_BR = 3;
    localparam int F_J  = 2;
    localparam int F_UI = 1;
    localparam int F_IL = 0;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [6:0]  flags;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic [5:0] r_functs [6];   // index in this list is the ALU code
    logic [5:0] valid_ops [8];

    instruction_decode dut (
        .clk           (clk),
        .reset         (reset),
        .DIR           (DIR),
        .ack_prev      (ack_prev),
        .data_in       (data_in),
        .DOR           (DOR),
        .ack_from_next (ack_from_next),
        .data_out      (data_out),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rd_addr       (rd_addr),
        .imm           (imm),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .jump          (jump),
        .use_imm       (use_imm),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    function automatic logic [6:0] act_flags();
        return {reg_write, mem_read, mem_write, branch, jump, use_imm, illegal};
    endfunction

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] im, input logic [3:0] al,
                                input logic [6:0] fl);
        vec_t v;
        v.instr = i; v.e.rs = rs; v.e.rt = rt; v.e.rd = rd;
        v.e.imm = im; v.e.alu = al; v.e.flags = fl;
        return v;
    endfunction

    // Reference model derived from the ISA field rules with plain arithmetic.
    function automatic exp_t ref_model(input logic [31:0] w);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] low16;
        logic [31:0] s16;
        int          idx;
        e     = '0;
        op    = w[31:26];
        fn    = w[5:0];
        e.rs  = w[25:21];
        e.rt  = w[20:16];
        low16 = w & 32'h0000_FFFF;
        s16   = (low16 >= 32'h0000_8000) ? (low16 - 32'h0001_0000) : low16;
        idx   = -1;
        for (int k = 0; k < 6; k++) if (fn == r_functs[k]) idx = k;
        if (op == 6'h00 && idx >= 0) begin
            e.rd = w[15:11]; e.alu = 4'(idx); e.flags[F_RW] = 1'b1;
        end else if (op == 6'h08) begin
            e.rd = e.rt; e.imm = s16; e.flags[F_RW] = 1'b1; e.flags[F_UI] = 1'b1;
        end else if (op == 6'h0C) begin
            e.rd = e.rt; e.imm = low16; e.alu = 4'd2; e.flags[F_RW] = 1'b1; e.flags[F_UI] = 1'b1;
        end else if (op == 6'h0D) begin
            e.rd = e.rt; e.imm = low16; e.alu = 4'd3; e.flags[F_RW] = 1'b1; e.flags[F_UI] = 1'b1;
        end else if (op == 6'h23) begin
            e.rd = e.rt; e.imm = s16; e.flags[F_RW] = 1'b1; e.flags[F_MR] = 1'b1; e.flags[F_UI] = 1'b1;
        end else if (op == 6'h2B) begin
            e.imm = s16; e.flags[F_MW] = 1'b1; e.flags[F_UI] = 1'b1;
        end else if (op == 6'h04) begin
            e.imm = s16 * 32'd4; e.alu = 4'd1; e.flags[F_BR] = 1'b1;
        end else if (op == 6'h02) begin
            e.imm = (w & 32'h03FF_FFFF) * 32'd4; e.flags[F_J] = 1'b1;
        end else begin
            e.flags[F_IL] = 1'b1;
        end
        if (e.rd == 5'd0) e.flags[F_RW] = 1'b0;
        return e;
    endfunction

    task automatic check_bundle(input string tag, input logic [31:0] instr, input exp_t e);
        check({tag, " rs_addr"},  32'(rs_addr),    32'(e.rs));
        check({tag, " rt_addr"},  32'(rt_addr),    32'(e.rt));
        check({tag, " rd_addr"},  32'(rd_addr),    32'(e.rd));
        check({tag, " imm"},      imm,             e.imm);
        check({tag, " alu_op"},   32'(alu_op),     32'(e.alu));
        check({tag, " flags"},    32'(act_flags()), 32'(e.flags));
        check({tag, " data_out"}, data_out,        instr);
    endtask

    // One full handshake; DUT must be idle on entry and is idle on exit.
    task automatic run_txn(input string tag, input logic [31:0] instr, input exp_t e, input int hold);
        int n;
        DIR = 1'b1; data_in = instr;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack_prev && n < 8);
        check({tag, " ack_prev latency"}, 32'(n), 32'd1);
        check({tag, " DOR before decode"}, 32'(DOR), 32'd0);
        DIR = 1'b0; data_in = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!DOR && n < 8);
        check({tag, " DOR latency"}, 32'(n), 32'd1);
        check({tag, " ack_prev pulse width"}, 32'(ack_prev), 32'd0);
        check_bundle(tag, instr, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, " DOR held"}, 32'(DOR), 32'd1);
            check({tag, " data_out held"}, data_out, instr);
        end
        ack_from_next = 1'b1;
        @(negedge clk);
        ack_from_next = 1'b0;
        check({tag, " DOR after ack"}, 32'(DOR), 32'd0);
        check({tag, " data_out kept in idle"}, data_out, instr);
    endtask

    vec_t        vecs[$];
    logic [31:0] w;
    exp_t        e;
    int          pulses;

    initial begin
        r_functs  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
        valid_ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};

        // instr, rs, rt, rd, imm, alu, flags{rw,mr,mw,br,j,ui,il}
        vecs.push_back(mk(32'h0109_5020, 5'd8, 5'd9, 5'd10, 32'h0000_0000, 4'd0, 7'b1000000)); // ADD
        vecs.push_back(mk(32'h2128_FFFC, 5'd9, 5'd8, 5'd8,  32'hFFFF_FFFC, 4'd0, 7'b1000010)); // ADDI -4
        vecs.push_back(mk(32'h3128_FFFC, 5'd9, 5'd8, 5'd8,  32'h0000_FFFC, 4'd2, 7'b1000010)); // ANDI
        vecs.push_back(mk(32'h1109_FFFF, 5'd8, 5'd9, 5'd0,  32'hFFFF_FFFC, 4'd1, 7'b0001000)); // BEQ -1
        vecs.push_back(mk(32'h0800_0010, 5'd0, 5'd0, 5'd0,  32'h0000_0040, 4'd0, 7'b0000100)); // J
        vecs.push_back(mk(32'hFC00_0000, 5'd0, 5'd0, 5'd0,  32'h0000_0000, 4'd0, 7'b0000001)); // bad op
        vecs.push_back(mk(32'h0109_503F, 5'd8, 5'd9, 5'd0,  32'h0000_0000, 4'd0, 7'b0000001)); // bad funct
        vecs.push_back(mk(32'h3528_8001, 5'd9, 5'd8, 5'd8,  32'h0000_8001, 4'd3, 7'b1000010)); // ORI
        vecs.push_back(mk(32'h8D0A_0008, 5'd8, 5'd10, 5'd10, 32'h0000_0008, 4'd0, 7'b1100010)); // LW
        vecs.push_back(mk(32'hAD0A_FFF0, 5'd8, 5'd10, 5'd0, 32'hFFFF_FFF0, 4'd0, 7'b0010010)); // SW
        vecs.push_back(mk(32'h2000_8005, 5'd0, 5'd0, 5'd0,  32'hFFFF_8005, 4'd0, 7'b0000010)); // ADDI to r0
        vecs.push_back(mk(32'h0109_0022, 5'd8, 5'd9, 5'd0,  32'h0000_0000, 4'd1, 7'b0000000)); // SUB to r0
        vecs.push_back(mk(32'h0109_5024, 5'd8, 5'd9, 5'd10, 32'h0000_0000, 4'd2, 7'b1000000)); // AND
        vecs.push_back(mk(32'h0109_5025, 5'd8, 5'd9, 5'd10, 32'h0000_0000, 4'd3, 7'b1000000)); // OR
        vecs.push_back(mk(32'h0109_5026, 5'd8, 5'd9, 5'd10, 32'h0000_0000, 4'd4, 7'b1000000)); // XOR
        vecs.push_back(mk(32'h0109_502A, 5'd8, 5'd9, 5'd10, 32'h0000_0000, 4'd5, 7'b1000000)); // SLT

        // Reset state
        reset = 1'b1; DIR = 1'b0; ack_from_next = 1'b0; data_in = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check("reset DOR", 32'(DOR), 32'd0);
        check("reset ack_prev", 32'(ack_prev), 32'd0);
        check("reset data_out", data_out, 32'h0);
        check("reset imm", imm, 32'h0);
        check("reset flags", 32'(act_flags()), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vector table
        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].instr, vecs[i].e, i % 3);

        // Randomized instructions against the reference model
        for (int r = 0; r < 40; r++) begin
            w = $urandom;
            if (r % 4 != 3) w[31:26] = valid_ops[$urandom_range(0, 7)];
            if (w[31:26] == 6'h00 && $urandom_range(0, 9) < 7) w[5:0] = r_functs[$urandom_range(0, 5)];
            run_txn($sformatf("rand%0d", r), w, ref_model(w), $urandom_range(0, 3));
        end

        // Stall: DOR held 20 cycles while upstream keeps DIR high with the next word
        DIR = 1'b1; data_in = 32'h0109_5020;
        @(negedge clk);
        check("stall first ack_prev", 32'(ack_prev), 32'd1);
        data_in = 32'h3528_8001;
        @(negedge clk);
        check("stall DOR up", 32'(DOR), 32'd1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack_prev) pulses++;
            check("stall DOR held", 32'(DOR), 32'd1);
            check("stall data_out held", data_out, 32'h0109_5020);
        end
        check("stall second ack_prev count", 32'(pulses), 32'd0);
        check_bundle("stall held", 32'h0109_5020, ref_model(32'h0109_5020));
        ack_from_next = 1'b1;
        @(negedge clk);
        ack_from_next = 1'b0;
        check("stall DOR released", 32'(DOR), 32'd0);
        check("stall no early capture", 32'(ack_prev), 32'd0);
        @(negedge clk);
        check("stall next capture", 32'(ack_prev), 32'd1);
        DIR = 1'b0;
        @(negedge clk);
        check("stall next DOR", 32'(DOR), 32'd1);
        check_bundle("stall next", 32'h3528_8001, ref_model(32'h3528_8001));
        ack_from_next = 1'b1;
        @(negedge clk);
        check("stall next DOR released", 32'(DOR), 32'd0);

        // ack_from_next while idle is ignored and outputs keep their values
        repeat (3) begin
            @(negedge clk);
            check("idle ack DOR", 32'(DOR), 32'd0);
            check("idle ack data_out", data_out, 32'h3528_8001);
        end

        // ack already high before DOR: bundle is valid for exactly one cycle
        DIR = 1'b1; data_in = 32'h8D0A_0008;
        @(negedge clk);
        check("early ack ack_prev", 32'(ack_prev), 32'd1);
        DIR = 1'b0;
        @(negedge clk);
        check("early ack DOR", 32'(DOR), 32'd1);
        check_bundle("early ack", 32'h8D0A_0008, ref_model(32'h8D0A_0008));
        @(negedge clk);
        check("early ack DOR one cycle", 32'(DOR), 32'd0);
        ack_from_next = 1'b0;
        @(negedge clk);

        // Reset while waiting for downstream ack: everything drops at once
        DIR = 1'b1; data_in = 32'h0109_5020;
        @(negedge clk);
        DIR = 1'b0;
        @(negedge clk);
        check("pre-reset DOR", 32'(DOR), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset DOR", 32'(DOR), 32'd0);
        check("async reset ack_prev", 32'(ack_prev), 32'd0);
        check("async reset data_out", data_out, 32'h0);
        check("async reset rd_addr", 32'(rd_addr), 32'd0);
        check("async reset flags", 32'(act_flags()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset while ack_prev is high: held instruction discarded
        DIR = 1'b1; data_in = 32'h1109_FFFF;
        @(negedge clk);
        check("pre-reset ack_prev", 32'(ack_prev), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset ack_prev in decode", 32'(ack_prev), 32'd0);
        DIR = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (DOR) pulses++;
        end
        check("discarded instr no DOR", 32'(pulses), 32'd0);
        run_txn("after reset", 32'h0800_0010, ref_model(32'h0800_0010), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
